alu_seq_ctrl: RTL

- Instruction sequencer that drives the 16-bit ALU: accepts host instructions over valid/ready and reads operands from an 8x16 register file.
- Issues opcode/A/B to the ALU, waits a fixed latency, then writes the result back and updates a 4-bit status register from the ALU flags.
- Sits between the host command interface and the ALU as the initiating end of the ALU operand/opcode interface.

---
 rtl/alu_seq_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// Instruction sequencer for the 16-bit ALU: issues operands from an 8-entry register file,
// waits ALU_LAT cycles, retires the result. Define ALU_SEQ_CTRL_ZERO_REG_EN to hardwire R0 to zero.
module alu_seq_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              done,
  output logic              err,
  output logic [3:0]        status,
  input  logic [2:0]        rb_addr,
  output logic [DATA_W-1:0] rb_data
);

`ifdef ALU_SEQ_CTRL_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  typedef enum logic {IDLE, EXEC} state_t;
  typedef enum logic [1:0] {CLS_W, CLS_C, CLS_N, CLS_ILL} op_class_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [2:0]        rd_reg;
  logic [DATA_W-1:0] rf_reg [8];
  logic [7:0]        wr_en;
  logic              accept, retire;
  op_class_t         cls;
  logic              unused_reserved;

  // Priority order matters: specific illegal codes are matched before their wider groups.
  function automatic op_class_t op_class(input logic [4:0] op);
    op_class_t c;
    casez (op)
      5'b00011: c = CLS_ILL;
      5'b00???: c = CLS_W;
      5'b01???: c = CLS_ILL;
      5'b1000?: c = CLS_C;
      5'b1001?: c = CLS_ILL;
      5'b10110: c = CLS_ILL;
      5'b101??: c = CLS_N;
      5'b11000: c = CLS_N;
      5'b110??: c = CLS_W;
      default:  c = CLS_N;
    endcase
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] rf_read(input logic [2:0] addr);
    logic [DATA_W-1:0] v;
    v = rf_reg[addr];
    if (ZERO_REG && addr == 3'd0) v = '0;
    return v;
  endfunction

  assign unused_reserved = instr[0];
  assign instr_ready     = (state_reg == IDLE);
  assign accept          = instr_ready && instr_valid;
  assign retire          = (state_reg == EXEC) && (cnt_reg == 4'd0);
  assign cls             = op_class(alu_op);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_wr_en
      if (ZERO_REG && gi == 0) begin : g_r0
        assign wr_en[gi] = 1'b0;
      end else begin : g_rn
        assign wr_en[gi] = retire && (cls == CLS_W) && (rd_reg == 3'(gi));
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (instr_valid) begin
          state_next = EXEC;
          cnt_next   = LAT_M1;
        end
      end
      EXEC: begin
        if (cnt_reg == 4'd0) state_next = IDLE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rd_reg    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      status    <= '0;
      rb_data   <= '0;
      for (int i = 0; i < 8; i++) rf_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done      <= retire;
      err       <= retire && (cls == CLS_ILL);
      // Sampled before this edge's writeback, so a same-address write shows up one cycle later.
      rb_data   <= rf_read(rb_addr);
      if (accept) begin
        alu_op <= instr[15:11];
        rd_reg <= instr[10:8];
        alu_a  <= rf_read(instr[7:5]);
        alu_b  <= instr[1] ? imm : rf_read(instr[4:2]);
      end
      if (retire) begin
        if (cls == CLS_W)      status <= alu_flags;
        else if (cls == CLS_C) status <= '0;
      end
      for (int i = 0; i < 8; i++) begin
        if (wr_en[i]) rf_reg[i] <= alu_result;
      end
    end
  end

endmodule
